// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int M0 = 0;
    localparam int M1 = 1;

    function automatic logic [1:0] onehot_gnt(arb_state_t s);
        case (s)
            GNT0:    return 2'b01;
            GNT1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic single-beat Wishbone bus bundle, 32-bit address and data.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  ack, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output ack, dat_sm
    );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter with a hold limit that pre-empts a long-running owner.
// Define WSHB_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed M1 priority.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] gnt
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);

    arb_state_t    state_q, state_d;
    arb_state_t    tie_state;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          req0, req1, sack, limit_hit;

    assign req0 = wshb_ifs0.cyc;
    assign req1 = wshb_ifs1.cyc;
    assign sack = wshb_ifm.ack;

    // The ack arriving this cycle is the one that fills the hold budget.
    assign limit_hit = sack && (hold_q >= HoldMax - HW'(1));
    assign hold_inc  = (hold_q == HoldMax) ? hold_q : hold_q + HW'(1);

`ifdef WSHB_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    assign tie_state = (last_q == 1'(M1)) ? GNT0 : GNT1;

    always_comb begin
        last_d = last_q;
        if (state_d == GNT0) last_d = 1'(M0);
        if (state_d == GNT1) last_d = 1'(M1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'(M1);
        else        last_q <= last_d;
    end
`else
    assign tie_state = GNT1;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) state_d = tie_state;
                else if (req1)    state_d = GNT1;
                else if (req0)    state_d = GNT0;
            end
            GNT0: begin
                if (!req0 || (limit_hit && req1)) state_d = req1 ? GNT1 : IDLE;
                else if (sack)                    hold_d  = hold_inc;
            end
            GNT1: begin
                if (!req1 || (limit_hit && req0)) state_d = req0 ? GNT0 : IDLE;
                else if (sack)                    hold_d  = hold_inc;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) hold_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    logic sel0, sel1;
    assign sel0 = (state_q == GNT0);
    assign sel1 = (state_q == GNT1);
    assign gnt  = onehot_gnt(state_q);

    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.sel    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        if (sel0) begin
            wshb_ifm.cyc    = wshb_ifs0.cyc;
            wshb_ifm.stb    = wshb_ifs0.stb;
            wshb_ifm.we     = wshb_ifs0.we;
            wshb_ifm.adr    = wshb_ifs0.adr;
            wshb_ifm.sel    = wshb_ifs0.sel;
            wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
            wshb_ifm.cti    = wshb_ifs0.cti;
            wshb_ifm.bte    = wshb_ifs0.bte;
        end else if (sel1) begin
            wshb_ifm.cyc    = wshb_ifs1.cyc;
            wshb_ifm.stb    = wshb_ifs1.stb;
            wshb_ifm.we     = wshb_ifs1.we;
            wshb_ifm.adr    = wshb_ifs1.adr;
            wshb_ifm.sel    = wshb_ifs1.sel;
            wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
            wshb_ifm.cti    = wshb_ifs1.cti;
            wshb_ifm.bte    = wshb_ifs1.bte;
        end
    end

    assign wshb_ifs0.ack    = sel0 & sack;
    assign wshb_ifs1.ack    = sel1 & sack;
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed plus random bench for wshb_arbiter against a transaction-level ownership model.
module tb_wshb_arbiter;

    localparam int MaxHold = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst;
    logic [1:0] gnt;

    assign rst = ~rst_n;
    always #5 clk = ~clk;

    wshb_if if0 (.clk(clk), .rst(rst));
    wshb_if if1 (.clk(clk), .rst(rst));
    wshb_if ifm (.clk(clk), .rst(rst));

    wshb_arbiter #(.MAX_HOLD(MaxHold)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wshb_ifs0 (if0),
        .wshb_ifs1 (if1),
        .wshb_ifm  (ifm),
        .gnt       (gnt)
    );

    // Model: owner -1 = nobody, else master index; hold = acks counted for owner.
    int own  = -1;
    int hold = 0;
    int last = 1;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own  = -1;
        hold = 0;
        last = 1;
    endtask

    task automatic check_outputs();
        logic [31:0] e_adr, e_dat, e_misc;
        logic        e_cyc, e_stb, e_we;
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0; e_dat = 0; e_misc = 0;
        if (own == 0) begin
            e_cyc = if0.cyc; e_stb = if0.stb; e_we = if0.we; e_adr = if0.adr;
            e_dat = if0.dat_ms; e_misc = {23'd0, if0.sel, if0.cti, if0.bte};
        end else if (own == 1) begin
            e_cyc = if1.cyc; e_stb = if1.stb; e_we = if1.we; e_adr = if1.adr;
            e_dat = if1.dat_ms; e_misc = {23'd0, if1.sel, if1.cti, if1.bte};
        end
        check("gnt", 32'(gnt), (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0);
        check("s_cyc", 32'(ifm.cyc), 32'(e_cyc));
        check("s_stb", 32'(ifm.stb), 32'(e_stb));
        check("s_we", 32'(ifm.we), 32'(e_we));
        check("s_adr", ifm.adr, e_adr);
        check("s_dat", ifm.dat_ms, e_dat);
        check("s_sel_cti_bte", {23'd0, ifm.sel, ifm.cti, ifm.bte}, e_misc);
        check("ack0", 32'(if0.ack), 32'((own == 0) && ifm.ack));
        check("ack1", 32'(if1.ack), 32'((own == 1) && ifm.ack));
        check("dat_sm0", if0.dat_sm, ifm.dat_sm);
        check("dat_sm1", if1.dat_sm, ifm.dat_sm);
    endtask

    // One clock: check at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        int nxt, nh, cnt;
        bit c0, c1, a, mine, oth;
        @(negedge clk);
        check_outputs();
        c0 = if0.cyc; c1 = if1.cyc; a = ifm.ack;
        nh = 0;
        if (!rst_n) begin
            nxt = -1;
        end else if (own < 0) begin
`ifdef WSHB_ARB_ROUND_ROBIN_EN
            if (c0 && c1) nxt = (last == 1) ? 0 : 1;
`else
            if (c0 && c1) nxt = 1;
`endif
            else if (c1)  nxt = 1;
            else if (c0)  nxt = 0;
            else          nxt = -1;
        end else begin
            mine = (own == 0) ? c0 : c1;
            oth  = (own == 0) ? c1 : c0;
            cnt  = hold + int'(a);
            if (cnt > MaxHold) cnt = MaxHold;
            if (!mine || (a && cnt == MaxHold && oth)) nxt = oth ? 1 - own : -1;
            else                                       nxt = own;
            nh = (nxt == own) ? cnt : 0;
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            if (nxt >= 0 && nxt != own) last = nxt;
            own  = nxt;
            hold = nh;
        end
        #1;
    endtask

    initial begin
        logic       ack_v;
        logic [1:0] exp_tie;
        if0.cyc = 0; if0.stb = 0; if0.we = 0; if0.adr = 0; if0.sel = 0; if0.dat_ms = 0;
        if0.cti = 0; if0.bte = 0;
        if1.cyc = 0; if1.stb = 0; if1.we = 0; if1.adr = 0; if1.sel = 0; if1.dat_ms = 0;
        if1.cti = 0; if1.bte = 0;
        ifm.ack = 0; ifm.dat_sm = 0;
        model_reset();

        // Reset state
        repeat (2) tick();
        rst_n = 1'b1;

        // 1: M0 alone, continuous writes at 0,4,8..
        if0.cyc = 1; if0.stb = 1; if0.we = 1; if0.sel = 4'hf; if0.adr = 0;
        if0.dat_ms = $urandom;
        tick();
        check("t1_gnt_latency", 32'(gnt), 32'd1);
        for (int i = 0; i < 12; i++) begin
            ack_v = 1'($urandom_range(0, 1));
            ifm.ack = ack_v; ifm.dat_sm = $urandom;
            tick();
            if (ack_v) begin
                if0.adr = if0.adr + 4;
                if0.dat_ms = $urandom;
            end
        end
        ifm.ack = 0;
        check("t1_gnt_held", 32'(gnt), 32'd1);

        // 4: M0 drops with M1 idle, later M1 requests
        if0.cyc = 0; if0.stb = 0;
        tick();
        check("t4_gnt_idle", 32'(gnt), 32'd0);
        check("t4_cyc_idle", 32'(ifm.cyc), 32'd0);
        tick();
        if1.cyc = 1; if1.stb = 1; if1.we = 0; if1.adr = 32'h100; if1.sel = 4'hf;
        tick();
        check("t4_gnt_m1", 32'(gnt), 32'd2);

        // 6: read data routed to M1 only, M0 waiting
        if0.cyc = 1; if0.stb = 1;
        ifm.dat_sm = 32'hA5A5_A5A5; ifm.ack = 1;
        #1;
        check("t6_ack1", 32'(if1.ack), 32'd1);
        check("t6_dat1", if1.dat_sm, 32'hA5A5_A5A5);
        check("t6_ack0", 32'(if0.ack), 32'd0);
        tick();

        // 5: asynchronous reset mid-transfer under GNT1
        check("t5_pre_gnt", 32'(gnt), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_cyc", 32'(ifm.cyc), 32'd0);
        check("t5_stb", 32'(ifm.stb), 32'd0);
        check("t5_ack0", 32'(if0.ack), 32'd0);
        check("t5_ack1", 32'(if1.ack), 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        if0.cyc = 0; if0.stb = 0; if1.cyc = 0; if1.stb = 0; ifm.ack = 0;
        tick();

        // 3: simultaneous requests from IDLE, last grant M1
`ifdef WSHB_ARB_ROUND_ROBIN_EN
        exp_tie = 2'b01;
`else
        exp_tie = 2'b10;
`endif
        if0.cyc = 1; if0.stb = 1; if1.cyc = 1; if1.stb = 1;
        tick();
        check("t3_tie", 32'(gnt), 32'(exp_tie));
        if0.cyc = 0; if0.stb = 0; if1.cyc = 0; if1.stb = 0;
        repeat (2) tick();

        // 2: pre-emption after MaxHold acks
        if0.cyc = 1; if0.stb = 1;
        tick();
        tick();
        if1.cyc = 1; if1.stb = 1; ifm.ack = 1;
        for (int k = 1; k <= MaxHold; k++) begin
            tick();
            check("t2_gnt", 32'(gnt), (k < MaxHold) ? 32'd1 : 32'd2);
        end
        repeat (2) tick();
        if1.cyc = 0; if1.stb = 0; ifm.ack = 0;
        tick();
        check("t2_return", 32'(gnt), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) if0.cyc = ~if0.cyc;
            if ($urandom_range(0, 7) == 0) if1.cyc = ~if1.cyc;
            if0.stb = if0.cyc; if1.stb = if1.cyc;
            if0.adr = $urandom; if1.adr = $urandom;
            if0.dat_ms = $urandom; if1.dat_ms = $urandom;
            if0.we = 1'($urandom); if1.we = 1'($urandom);
            if0.sel = 4'($urandom); if1.sel = 4'($urandom);
            if0.cti = 3'($urandom); if1.cti = 3'($urandom);
            if0.bte = 2'($urandom); if1.bte = 2'($urandom);
            ifm.ack = 1'($urandom); ifm.dat_sm = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
